// File: rtl/ft_pkt_pkg.sv
// Shared types and header framing for the FT2232 OUT-FIFO packet scheduler.
// Header byte layout: {channel[1:0], payload_len_minus_1[5:0]}.
package ft_pkt_pkg;

    localparam int MAX_PAYLOAD = 64;
    localparam int HDR_CH_W    = 2;
    localparam int HDR_LEN_W   = $clog2(MAX_PAYLOAD);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } state_e;

    function automatic logic [7:0] hdr_pack(input logic [HDR_CH_W-1:0]  ch,
                                            input logic [HDR_LEN_W-1:0] len);
        return {ch, len};
    endfunction

endpackage

// File: rtl/ft_rr_pick.sv
// Combinational round-robin picker: the first requester after last_grant wins, wrapping.
// Rotates the request vector so the search starts at last_grant+1, isolates the lowest bit, rotates back.
module ft_rr_pick
    import ft_pkt_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]   req_i,
    input  logic [HDR_CH_W-1:0] last_grant_i,
    output logic [NUM_CH-1:0]   pick_o,
    output logic                any_o
);

    logic [HDR_CH_W-1:0] start;
    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic [NUM_CH-1:0]   pick_rot;
    logic [2*NUM_CH-1:0] pick_dbl;

    always_comb begin
        start = (last_grant_i == HDR_CH_W'(NUM_CH-1)) ? '0 : last_grant_i + HDR_CH_W'(1);
        req_dbl  = {req_i, req_i} >> start;
        req_rot  = req_dbl[NUM_CH-1:0];
        pick_rot = req_rot & (~req_rot + NUM_CH'(1));
        pick_dbl = {pick_rot, pick_rot} << start;
        pick_o   = pick_dbl[2*NUM_CH-1:NUM_CH];
        any_o    = |req_i;
    end

endmodule

// File: rtl/ft_tx_arbiter.sv
// Round-robin packet scheduler feeding the FT2232 OUT FIFO write port (60 MHz FIFO clock domain).
// Each grant emits one header byte followed by len_q+1 payload bytes from the granted channel.
module ft_tx_arbiter
    import ft_pkt_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                          fifo_clk_i,
    input  logic                          reset_i,
    input  logic [NUM_CH-1:0]             ch_req_i,
    input  logic [NUM_CH*HDR_LEN_W-1:0]   ch_len_i,
    input  logic [NUM_CH-1:0]             ch_valid_i,
    input  logic [NUM_CH*8-1:0]           ch_data_i,
    output logic [NUM_CH-1:0]             ch_ready_o,
    output logic [NUM_CH-1:0]             ch_done_o,
    output logic [NUM_CH-1:0]             grant_o,
    output logic                          busy_o,
    output logic                          wr_out_fifo_en_o,
    output logic [7:0]                    wr_out_fifo_data_o,
    input  logic                          wr_out_fifo_full_i,
    input  logic                          wr_out_fifo_afull_i
);

    state_e                 state_q, state_d;
    logic [NUM_CH-1:0]      grant_q, grant_d;
    logic [HDR_CH_W-1:0]    grant_idx_q, grant_idx_d;
    logic [HDR_CH_W-1:0]    last_grant_q, last_grant_d;
    logic [HDR_LEN_W-1:0]   len_q, len_d;
    logic [HDR_LEN_W-1:0]   cnt_q, cnt_d;
    logic                   wr_en_q, wr_en_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic [NUM_CH-1:0]      done_q, done_d;

    logic                   space;
    logic [NUM_CH-1:0]      pick;
    logic                   pick_any;
    logic [HDR_CH_W-1:0]    pick_idx;
    logic [HDR_LEN_W-1:0]   pick_len;
    logic                   sel_valid;
    logic [7:0]             sel_data;

    // The write is registered, so afull must also block: it lands one cycle after the decision.
    assign space = ~wr_out_fifo_full_i & ~wr_out_fifo_afull_i;

    ft_rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_rr_pick (
        .req_i        (ch_req_i),
        .last_grant_i (last_grant_q),
        .pick_o       (pick),
        .any_o        (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        pick_len = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick[i]) begin
                pick_idx = HDR_CH_W'(i);
                pick_len = ch_len_i[i*HDR_LEN_W +: HDR_LEN_W];
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q[i]) begin
                sel_valid = ch_valid_i[i];
                sel_data  = ch_data_i[i*8 +: 8];
            end
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        done_d       = '0;
        ch_ready_o   = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d     = pick;
                    grant_idx_d = pick_idx;
                    len_d       = pick_len;
                    state_d     = HEADER;
                end
            end

            HEADER: begin
                if (space) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = hdr_pack(grant_idx_q, len_q);
                    cnt_d     = len_q;
                    state_d   = PAYLOAD;
                end
            end

            PAYLOAD: begin
                ch_ready_o = grant_q & {NUM_CH{space}};
                if (space && sel_valid) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = sel_data;
                    if (cnt_q == '0) begin
                        done_d       = grant_q;
                        last_grant_d = grant_idx_q;
                        grant_d      = '0;
                        state_d      = IDLE;
                    end else begin
                        cnt_d = cnt_q - HDR_LEN_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // NOTE: synchronous reset; sequential state is updated with non-blocking assignments only.
    always_ff @(posedge fifo_clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grant_idx_q  <= '0;
            last_grant_q <= HDR_CH_W'(NUM_CH-1);
            len_q        <= '0;
            cnt_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            done_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            done_q       <= done_d;
        end
    end

    assign grant_o            = grant_q;
    assign busy_o             = (state_q != IDLE);
    assign ch_done_o          = done_q;
    assign wr_out_fifo_en_o   = wr_en_q;
    assign wr_out_fifo_data_o = wr_data_q;

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Directed scoreboard bench for ft_tx_arbiter: expected OUT-FIFO bytes (with done pulses) are
// queued when a packet is requested and popped as the DUT writes them.
module tb_ft_tx_arbiter;

    localparam int NUM_CH = 4;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] done;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  ch_req = '0;
    logic [23:0] ch_len = '0;
    logic [3:0]  ch_valid = '0;
    logic [31:0] ch_data = '0;
    logic [3:0]  ch_ready;
    logic [3:0]  ch_done;
    logic [3:0]  grant;
    logic        busy;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full = 1'b0;
    logic        afull = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_count = 0;
    int first_wr = -1;
    int last_wr = -1;
    bit prev_space = 1'b1;

    exp_t       exp_q[$];
    logic [7:0] src_mem [4][64];
    int         src_cnt [4];
    int         src_rd [4];
    bit         stall [4];
    bit         acc [4];

    ft_tx_arbiter #(.NUM_CH(NUM_CH)) dut (
        .fifo_clk_i          (clk),
        .reset_i             (reset),
        .ch_req_i            (ch_req),
        .ch_len_i            (ch_len),
        .ch_valid_i          (ch_valid),
        .ch_data_i           (ch_data),
        .ch_ready_o          (ch_ready),
        .ch_done_o           (ch_done),
        .grant_o             (grant),
        .busy_o              (busy),
        .wr_out_fifo_en_o    (wr_en),
        .wr_out_fifo_data_o  (wr_data),
        .wr_out_fifo_full_i  (full),
        .wr_out_fifo_afull_i (afull)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int c = 0; c < 4; c++) begin
            ch_valid[c] = (src_rd[c] < src_cnt[c]) && !stall[c];
            ch_data[c*8 +: 8] = (src_rd[c] < src_cnt[c]) ? src_mem[c][src_rd[c]] : 8'h00;
        end
    endtask

    task automatic queue_pkt(input int ch, input int len, input logic [7:0] base);
        exp_t e;
        e.data = {ch[1:0], len[5:0]};
        e.done = 4'b0000;
        exp_q.push_back(e);
        for (int i = 0; i <= len; i++) begin
            src_mem[ch][i] = base + 8'(i);
            e.data = base + 8'(i);
            e.done = (i == len) ? (4'b0001 << ch) : 4'b0000;
            exp_q.push_back(e);
        end
        src_cnt[ch] = len + 1;
        src_rd[ch]  = 0;
        ch_len[ch*6 +: 6] = len[5:0];
        ch_req[ch] = 1'b1;
    endtask

    // Sample outputs mid-cycle and score any OUT-FIFO write.
    task automatic tick_neg();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (wr_en === 1'b1) begin
            wr_count++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            check("wr_after_space", 32'(prev_space), 32'd1);
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL wr_unexpected observed=%02h required=no_write", wr_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_data", 32'(wr_data), 32'(e.data));
                check("done_at_wr", 32'(ch_done), 32'(e.done));
            end
        end else begin
            check("done_idle", 32'(ch_done), 32'd0);
        end
        check("ready_only_grant", 32'(ch_ready & ~grant), 32'd0);
        prev_space = !full && !afull;
        for (int c = 0; c < 4; c++) acc[c] = ch_valid[c] && ch_ready[c];
    endtask

    // Advance sources past accepted bytes; a requester drops req once its last byte is taken.
    task automatic tick_pos();
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (acc[c]) begin
                src_rd[c]++;
                if (src_rd[c] == src_cnt[c]) ch_req[c] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic tick();
        tick_neg();
        tick_pos();
    endtask

    task automatic wait_writes(input string tag, input int target, input int budget);
        int n = 0;
        while (wr_count < target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        assert (wr_count >= target) else begin
            errors++;
            $error("FAIL %s observed=%0d required=%0d writes", tag, wr_count, target);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s observed=%0d required=0 bytes outstanding", tag, exp_q.size());
        end
    endtask

    initial begin
        int w0;
        int n0;
        int req_cyc;

        for (int c = 0; c < 4; c++) begin
            src_cnt[c] = 0;
            src_rd[c]  = 0;
            stall[c]   = 1'b0;
            acc[c]     = 1'b0;
        end
        drive();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        tick_neg();
        check("rst_en", 32'(wr_en), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check("rst_ready", 32'(ch_ready), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick_pos();

        // Round-robin: all four request len=0 together, served 0,1,2,3.
        queue_pkt(0, 0, 8'h10);
        queue_pkt(1, 0, 8'h20);
        queue_pkt(2, 0, 8'h30);
        queue_pkt(3, 0, 8'h40);
        drive();
        wait_drain("rr_drain", 100);

        // Single packet on ch1, 3 bytes: 0x42,A1,A2,A3 back to back, 2-cycle request latency.
        first_wr = -1;
        queue_pkt(1, 2, 8'hA1);
        drive();
        req_cyc = cyc + 1;
        tick();
        tick_neg();
        check("single_grant", 32'(grant), 32'h2);
        check("single_busy", 32'(busy), 32'd1);
        tick_pos();
        wait_drain("single_drain", 50);
        check("single_latency", 32'(first_wr - req_cyc), 32'd2);
        check("single_span", 32'(last_wr - first_wr), 32'd3);
        tick_neg();
        check("single_idle_busy", 32'(busy), 32'd0);
        check("single_idle_grant", 32'(grant), 32'd0);
        tick_pos();

        // Source stall on ch2 with req dropped mid-packet; a late len change must be ignored.
        w0 = wr_count;
        queue_pkt(2, 7, 8'h60);
        drive();
        wait_writes("stall_start", w0 + 4, 50);
        ch_len[12 +: 6] = 6'h3F;
        ch_req[2] = 1'b0;
        stall[2] = 1'b1;
        drive();
        tick();
        n0 = wr_count;
        tick();
        tick();
        stall[2] = 1'b0;
        drive();
        tick();
        check("stall_no_wr", 32'(wr_count), 32'(n0));
        wait_drain("stall_drain", 50);
        check("stall_total", 32'(wr_count - w0), 32'd9);

        // Afull held 5 cycles around the 10th byte of a 64-byte packet.
        w0 = wr_count;
        queue_pkt(0, 63, 8'h80);
        drive();
        wait_writes("afull_start", w0 + 10, 50);
        afull = 1'b1;
        tick();
        n0 = wr_count;
        repeat (4) tick();
        afull = 1'b0;
        tick();
        check("afull_no_wr", 32'(wr_count), 32'(n0));
        wait_drain("afull_drain", 200);
        check("afull_total", 32'(wr_count - w0), 32'd65);

        // Maximum length on ch3 with a 2-cycle full in the middle.
        w0 = wr_count;
        first_wr = -1;
        queue_pkt(3, 63, 8'hC0);
        drive();
        wait_writes("max_start", w0 + 30, 100);
        full = 1'b1;
        tick();
        tick();
        full = 1'b0;
        wait_drain("max_drain", 200);
        check("max_total", 32'(wr_count - w0), 32'd65);
        check("max_span", 32'(last_wr - first_wr), 32'd66);

        // Reset after 4 of 16 payload bytes on ch0.
        w0 = wr_count;
        queue_pkt(0, 15, 8'h20);
        drive();
        wait_writes("rstmid_start", w0 + 5, 50);
        reset = 1'b1;
        ch_req = '0;
        for (int c = 0; c < 4; c++) begin
            src_cnt[c] = 0;
            src_rd[c]  = 0;
            stall[c]   = 1'b0;
        end
        drive();
        tick();
        exp_q.delete();
        reset = 1'b0;
        tick_neg();
        check("rstmid_en", 32'(wr_en), 32'd0);
        check("rstmid_data", 32'(wr_data), 32'd0);
        check("rstmid_ready", 32'(ch_ready), 32'd0);
        check("rstmid_done", 32'(ch_done), 32'd0);
        check("rstmid_grant", 32'(grant), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        tick_pos();
        n0 = wr_count;
        repeat (3) tick();
        check("rstmid_quiet", 32'(wr_count), 32'(n0));

        // Fresh packet from ch3 after the abort: header 0xC2.
        queue_pkt(3, 2, 8'hD0);
        drive();
        wait_drain("fresh_drain", 50);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
